kc_ls1u_intc: RTL and testbench

Memory-mapped interrupt controller for the KC_LS1u_plus core. It collects up to NSRC external interrupt requests and latches them into pending bits. It applies mask and fixed priority, then drives the core's single `INT` input plus an interrupt code. It also holds the interrupt-vector base that feeds `IVEC_addr`. It sits on the core's 24-bit data bus as a small register window; software acknowledges and ends service through register writes.

---
 rtl/kc_intc_pkg.sv | 31 +++
 rtl/kc_intc_sync_edge.sv | 35 +++
 rtl/kc_ls1u_intc.sv | 136 +++++++++++++
 tb/tb_kc_ls1u_intc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/kc_intc_pkg.sv
// Shared types and register map for the KC_LS1u_plus interrupt controller.
package kc_intc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ASSERT    = 2'd1,
    INSERVICE = 2'd2
  } intc_state_t;

  localparam logic [2:0] INTC_PEND  = 3'd0;
  localparam logic [2:0] INTC_MASK  = 3'd1;
  localparam logic [2:0] INTC_EDGE  = 3'd2;
  localparam logic [2:0] INTC_CTRL  = 3'd3;
  localparam logic [2:0] INTC_ACK   = 3'd4;
  localparam logic [2:0] INTC_IVEC0 = 3'd5;
  localparam logic [2:0] INTC_IVEC1 = 3'd6;
  localparam logic [2:0] INTC_IVEC2 = 3'd7;

  localparam int INTC_GEN_BIT = 0;
  localparam int INTC_EOI_BIT = 1;

  // Lowest set index wins (highest priority).
  function automatic logic [2:0] intc_prio(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/kc_intc_sync_edge.sv
// Per-source 2-flop synchronizer with optional rising-edge detect.
// Edge detect is present only when KC_INTC_EDGE_EN is defined.
module kc_intc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic lvl,
  output logic rise
);
  logic s1, s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
    end
  end

  assign lvl = s2;

`ifdef KC_INTC_EDGE_EN
  logic prev;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b0;
    else      prev <= s2;
  end
  assign rise = s2 & ~prev;
`else
  assign rise = 1'b0;
`endif

endmodule

// File: rtl/kc_ls1u_intc.sv
// Memory-mapped interrupt controller: pending/mask/priority, INT + INTCODE, IVEC base.
// Optional per-source edge triggering via KC_INTC_EDGE_EN.
module kc_ls1u_intc
  import kc_intc_pkg::*;
#(
  parameter int          NSRC       = 8,
  parameter logic [23:0] BASE_ADDR  = 24'hFFF000,
  parameter logic [23:0] IVEC_RESET = 24'hFF0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_i,
  input  logic [23:0]     daddr,
  input  logic            dwrite,
  input  logic [7:0]      ddata_i,
  output logic [7:0]      ddata_o,
  output logic            dsel_o,
  output logic            INT,
  output logic [2:0]      INTCODE,
  output logic [23:0]     IVEC_addr
);
  logic [NSRC-1:0] lvl, rise, pend, mask;
  logic [7:0]      pend8, mask8, sel_mask, rdata;
  logic [2:0]      off;
  logic            wr, gen, ack_wr, eoi_wr, sel_ok;
  intc_state_t     state;

  kc_intc_sync_edge u_sync [NSRC-1:0] (
    .clk  (clk),
    .rst  (rst),
    .irq  (irq_i),
    .lvl  (lvl),
    .rise (rise)
  );

  assign dsel_o = (daddr[23:3] == BASE_ADDR[23:3]);
  assign off    = daddr[2:0];
  assign wr     = dwrite & dsel_o;
  assign ack_wr = wr && (off == INTC_ACK) && (state == ASSERT);
  assign eoi_wr = wr && (off == INTC_CTRL) && ddata_i[INTC_EOI_BIT] && (state == INSERVICE);

`ifdef KC_INTC_EDGE_EN
  logic [NSRC-1:0] edge_sel, pend_edge, w1c, ack_clr;
  logic [7:0]      ack_hot;

  assign ack_hot = 8'b1 << INTCODE;
  assign ack_clr = ack_wr ? ack_hot[NSRC-1:0] : '0;
  assign w1c     = (wr && off == INTC_PEND) ? ddata_i[NSRC-1:0] : '0;
  assign pend    = (edge_sel & pend_edge) | (~edge_sel & lvl);

  // A new rise is OR-ed in last so it beats a same-cycle W1C or ACK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_sel  <= '0;
      pend_edge <= '0;
    end else begin
      if (wr && off == INTC_EDGE) edge_sel <= ddata_i[NSRC-1:0];
      pend_edge <= (pend_edge & ~w1c & ~ack_clr) | (rise & edge_sel);
    end
  end
`else
  logic unused_rise;
  assign unused_rise = ^rise;
  assign pend        = lvl;
`endif

  assign pend8    = 8'(pend);
  assign mask8    = 8'(mask);
  assign sel_mask = pend8 & mask8;
  assign sel_ok   = gen & sel_mask[INTCODE];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask      <= '0;
      gen       <= 1'b0;
      IVEC_addr <= IVEC_RESET;
    end else if (wr) begin
      case (off)
        INTC_MASK:  mask            <= ddata_i[NSRC-1:0];
        INTC_CTRL:  gen             <= ddata_i[INTC_GEN_BIT];
        INTC_IVEC0: IVEC_addr[7:0]   <= ddata_i;
        INTC_IVEC1: IVEC_addr[15:8]  <= ddata_i;
        INTC_IVEC2: IVEC_addr[23:16] <= ddata_i;
        default: ;
      endcase
    end
  end

  // Priority is sampled only when leaving IDLE; INTCODE holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      INT     <= 1'b0;
      INTCODE <= 3'd0;
    end else begin
      case (state)
        IDLE: if (gen && |sel_mask) begin
          state   <= ASSERT;
          INT     <= 1'b1;
          INTCODE <= intc_prio(sel_mask);
        end
        ASSERT: if (ack_wr) begin
          state <= INSERVICE;
          INT   <= 1'b0;
        end else if (!sel_ok) begin
          state <= IDLE;
          INT   <= 1'b0;
        end
        INSERVICE: if (eoi_wr) state <= IDLE;
        default: begin
          state <= IDLE;
          INT   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (off)
      INTC_PEND:  rdata = pend8;
      INTC_MASK:  rdata = mask8;
`ifdef KC_INTC_EDGE_EN
      INTC_EDGE:  rdata = 8'(edge_sel);
`endif
      INTC_CTRL:  rdata = {7'b0, gen};
      INTC_ACK:   rdata = {5'b0, INTCODE};
      INTC_IVEC0: rdata = IVEC_addr[7:0];
      INTC_IVEC1: rdata = IVEC_addr[15:8];
      INTC_IVEC2: rdata = IVEC_addr[23:16];
      default:    rdata = 8'h00;
    endcase
    ddata_o = dsel_o ? rdata : 8'h00;
  end

endmodule

// File: tb/tb_kc_ls1u_intc.sv
// Scoreboard bench for kc_ls1u_intc: stimulus queues expectations, a negedge monitor checks them.
module tb_kc_ls1u_intc;
  localparam logic [23:0] BASE = 24'hFFF000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  irq_i = 8'h00;
  logic [23:0] daddr = 24'h0;
  logic        dwrite = 1'b0;
  logic [7:0]  ddata_i = 8'h00;
  logic [7:0]  ddata_o;
  logic        dsel_o, INT;
  logic [2:0]  INTCODE;
  logic [23:0] IVEC_addr;

  kc_ls1u_intc #(.NSRC(8), .BASE_ADDR(BASE), .IVEC_RESET(24'hFF0000)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .daddr(daddr), .dwrite(dwrite),
    .ddata_i(ddata_i), .ddata_o(ddata_o), .dsel_o(dsel_o), .INT(INT),
    .INTCODE(INTCODE), .IVEC_addr(IVEC_addr)
  );

  always #5 clk = ~clk;

  // kind: 0 ddata_o, 1 INT, 2 INTCODE, 3 IVEC_addr, 4 dsel_o
  typedef struct {
    int          kind;
    logic [23:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [23:0] act;
      e = sb.pop_front();
      case (e.kind)
        0:       act = {16'h0, ddata_o};
        1:       act = {23'h0, INT};
        2:       act = {21'h0, INTCODE};
        3:       act = IVEC_addr;
        default: act = {23'h0, dsel_o};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [23:0] exp, input string name);
    sb.push_back('{kind: kind, exp: exp, name: name});
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    daddr   = BASE | {21'h0, off};
    ddata_i = d;
    dwrite  = 1'b1;
    @(posedge clk);
    #1;
    dwrite  = 1'b0;
    daddr   = 24'h0;
  endtask

  task automatic rd(input logic [2:0] off, input logic [7:0] exp, input string name);
    daddr = BASE | {21'h0, off};
    chk(0, {16'h0, exp}, name);
    daddr = 24'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    rst = 1'b1;
    tick(1);

    // reset state
    chk(1, 24'd0, "rst_int");
    chk(2, 24'd0, "rst_code");
    chk(3, 24'hFF0000, "rst_ivec");
    chk(4, 24'd0, "dsel_out");
    for (int i = 0; i < 5; i++) rd(3'(i), 8'h00, "rst_reg");
    daddr = BASE | 24'h5;
    chk(4, 24'd1, "dsel_in");
    daddr = 24'h0;

    // IVEC bytes
    wr(3'd5, 8'h12);
    wr(3'd6, 8'h34);
    wr(3'd7, 8'h56);
    chk(3, 24'h563412, "ivec_write");
    rd(3'd7, 8'h56, "ivec2_read");

    // priority among level sources 2 and 5
    irq_i = 8'h24;
    tick(4);
    chk(1, 24'd0, "no_int_gen0");
    wr(3'd1, 8'hFF);
    wr(3'd3, 8'h01);
    tick(1);
    chk(1, 24'd1, "prio_int");
    chk(2, 24'd2, "prio_code2");
    rd(3'd4, 8'h02, "ack_read");
    rd(3'd0, 8'h24, "pend_lvl");
    wr(3'd4, 8'h00);
    chk(1, 24'd0, "ack_drop");
    chk(2, 24'd2, "insvc_code");
    irq_i = 8'h20;
    tick(3);
    chk(1, 24'd0, "no_nest");
    wr(3'd3, 8'h03);
    chk(1, 24'd0, "eoi_idle");
    tick(1);
    chk(1, 24'd1, "reassert");
    chk(2, 24'd5, "prio_code5");

    // withdrawn request, then ACK outside ASSERT ignored
    wr(3'd1, 8'h00);
    tick(1);
    chk(1, 24'd0, "withdrawn");
    wr(3'd4, 8'h00);
    wr(3'd1, 8'hFF);
    tick(1);
    chk(1, 24'd1, "ack_ignored");
    chk(2, 24'd5, "reassert_code");
    wr(3'd4, 8'h00);
    irq_i = 8'h00;
    tick(3);
    wr(3'd3, 8'h02);
    tick(2);
    chk(1, 24'd0, "cleanup_idle");

    // W1C has no effect on a level source
    irq_i = 8'h01;
    tick(3);
    wr(3'd0, 8'h01);
    rd(3'd0, 8'h01, "w1c_level");
    irq_i = 8'h00;
    tick(3);
    rd(3'd0, 8'h00, "level_gone");

`ifdef KC_INTC_EDGE_EN
    wr(3'd2, 8'hFF);
    rd(3'd2, 8'hFF, "edge_rw");
    wr(3'd2, 8'h08);
    wr(3'd1, 8'h08);
    wr(3'd3, 8'h01);
    irq_i = 8'h08;
    tick(1);
    irq_i = 8'h00;
    tick(2);
    chk(1, 24'd0, "edge_int_e3");
    tick(1);
    chk(1, 24'd1, "edge_int_e4");
    chk(2, 24'd3, "edge_code");
    rd(3'd0, 8'h08, "edge_pend");
    wr(3'd4, 8'h00);
    chk(1, 24'd0, "edge_ack");
    rd(3'd0, 8'h00, "edge_ack_clr");
    wr(3'd3, 8'h03);
    tick(2);
    chk(1, 24'd0, "edge_eoi");

    // same-cycle rise and W1C on bit 0: set wins
    wr(3'd3, 8'h00);
    wr(3'd2, 8'h01);
    irq_i = 8'h01;
    tick(2);
    wr(3'd0, 8'h01);
    rd(3'd0, 8'h01, "collision");
    wr(3'd0, 8'h01);
    rd(3'd0, 8'h00, "w1c_edge");
    irq_i = 8'h00;
    wr(3'd2, 8'h00);
`else
    wr(3'd2, 8'hFF);
    rd(3'd2, 8'h00, "edge_absent");
`endif

    // asynchronous reset mid-operation
    wr(3'd1, 8'hFF);
    wr(3'd3, 8'h01);
    irq_i = 8'h80;
    tick(4);
    chk(1, 24'd1, "pre_rst_int");
    chk(2, 24'd7, "pre_rst_code");
    rst = 1'b0;
    #1;
    chk(1, 24'd0, "mid_rst_int");
    chk(2, 24'd0, "mid_rst_code");
    chk(3, 24'hFF0000, "mid_rst_ivec");
    rd(3'd1, 8'h00, "mid_rst_mask");
    rd(3'd3, 8'h00, "mid_rst_ctrl");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d pending want 0", sb.size());
      n_err += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
